mips_register_file: RTL and testbench

//   32-entry general-purpose register file for the MIPS-style single-cycle datapath.
//   Two combinational read ports feed ALU operands; one synchronous write port takes the writeback result.

---
 rtl/mips_register_file.sv | 66 ++++++
 tb/tb_mips_register_file.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mips_register_file.sv
// rtl/mips_register_file.sv - 32-entry MIPS register file, two combinational reads, one synchronous write
// Optional write-first forwarding on the read ports when REG_FILE_BYPASS_EN is defined.
module mips_register_file #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Reg_Write_i,
  input  logic [4:0]   Write_Register_i,
  input  logic [4:0]   Read_Register_1_i,
  input  logic [4:0]   Read_Register_2_i,
  input  logic [N-1:0] Write_Data_i,
  output logic [N-1:0] Read_Data_1_o,
  output logic [N-1:0] Read_Data_2_o
);

  // r0 has no storage; reads of address 0 are forced to zero below.
  logic [N-1:0] regs [1:31];
  logic         write_en;

  assign write_en = Reg_Write_i && (Write_Register_i != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[Write_Register_i] <= Write_Data_i;
    end
  end

  logic [N-1:0] stored_1;
  logic [N-1:0] stored_2;

  always_comb begin
    stored_1 = '0;
    stored_2 = '0;
    if (Read_Register_1_i != 5'd0) begin
      stored_1 = regs[Read_Register_1_i];
    end
    if (Read_Register_2_i != 5'd0) begin
      stored_2 = regs[Read_Register_2_i];
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic fwd_1;
  logic fwd_2;

  // Forwarding is gated by reset so an asserted reset still reads all zeros.
  assign fwd_1 = reset && write_en && (Read_Register_1_i == Write_Register_i);
  assign fwd_2 = reset && write_en && (Read_Register_2_i == Write_Register_i);

  always_comb begin
    Read_Data_1_o = fwd_1 ? Write_Data_i : stored_1;
    Read_Data_2_o = fwd_2 ? Write_Data_i : stored_2;
  end
`else
  always_comb begin
    Read_Data_1_o = stored_1;
    Read_Data_2_o = stored_2;
  end
`endif

endmodule

// File: tb/tb_mips_register_file.sv
// tb/tb_mips_register_file.sv - directed self-checking bench for mips_register_file
module tb_mips_register_file;

  localparam int N = 32;

  logic         clk;
  logic         reset;
  logic         Reg_Write_i;
  logic [4:0]   Write_Register_i;
  logic [4:0]   Read_Register_1_i;
  logic [4:0]   Read_Register_2_i;
  logic [N-1:0] Write_Data_i;
  logic [N-1:0] Read_Data_1_o;
  logic [N-1:0] Read_Data_2_o;

  int checks_run;
  int checks_failed;

  mips_register_file #(.N(N)) dut (
    .clk               (clk),
    .reset             (reset),
    .Reg_Write_i       (Reg_Write_i),
    .Write_Register_i  (Write_Register_i),
    .Read_Register_1_i (Read_Register_1_i),
    .Read_Register_2_i (Read_Register_2_i),
    .Write_Data_i      (Write_Data_i),
    .Read_Data_1_o     (Read_Data_1_o),
    .Read_Data_2_o     (Read_Data_2_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks_run++;
    if (got !== exp) begin
      checks_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge so inputs change well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_pair(input logic [4:0] a1, input logic [4:0] a2);
    Read_Register_1_i = a1;
    Read_Register_2_i = a2;
    #1;
  endtask

  logic [4:0]   wr_addr [4];
  logic [N-1:0] wr_data [4];
  logic [N-1:0] exp_rdw;

  initial begin
    checks_run       = 0;
    checks_failed    = 0;
    reset            = 1'b1;
    Reg_Write_i      = 1'b0;
    Write_Register_i = 5'd0;
    Read_Register_1_i = 5'd0;
    Read_Register_2_i = 5'd0;
    Write_Data_i     = '0;
    wr_addr = '{5'd2, 5'd4, 5'd25, 5'd31};
    wr_data = '{32'd7, 32'd20, 32'd6, 32'd78};

    // Reset held low, reads all zero
    #3 reset = 1'b0;
    tick();
    read_pair(5'd0, 5'd2);
    check_value("rst_r0", Read_Data_1_o, 32'd0);
    check_value("rst_r2", Read_Data_2_o, 32'd0);
    read_pair(5'd31, 5'd31);
    check_value("rst_r31", Read_Data_1_o, 32'd0);

    reset = 1'b1;
    repeat (3) tick();
    read_pair(5'd2, 5'd31);
    check_value("idle_r2", Read_Data_1_o, 32'd0);
    check_value("idle_r31", Read_Data_2_o, 32'd0);

    // Write to r0 discarded
    Reg_Write_i = 1'b1;
    Write_Register_i = 5'd0;
    Write_Data_i = 32'd3;
    read_pair(5'd0, 5'd0);
    tick();
    check_value("r0_wr_p1", Read_Data_1_o, 32'd0);
    check_value("r0_wr_p2", Read_Data_2_o, 32'd0);

    // Consecutive writes with both ports tracking the write address
    for (int i = 0; i < 4; i++) begin
      Write_Register_i = wr_addr[i];
      Write_Data_i = wr_data[i];
      read_pair(wr_addr[i], wr_addr[i]);
      tick();
      check_value($sformatf("wr%0d_p1", i), Read_Data_1_o, wr_data[i]);
      check_value($sformatf("wr%0d_p2", i), Read_Data_2_o, wr_data[i]);
    end
    Reg_Write_i = 1'b0;
    read_pair(5'd2, 5'd4);
    check_value("r2_hold", Read_Data_1_o, 32'd7);
    check_value("r4_hold", Read_Data_2_o, 32'd20);

    // Disabled write leaves r4 unchanged
    Write_Register_i = 5'd4;
    Write_Data_i = 32'hFFFF_FFFF;
    read_pair(5'd4, 5'd25);
    tick();
    check_value("nowr_r4", Read_Data_1_o, 32'd20);
    check_value("nowr_r25", Read_Data_2_o, 32'd6);

    // Independent ports, then asynchronous reset mid-cycle
    read_pair(5'd2, 5'd31);
    check_value("dual_p1", Read_Data_1_o, 32'd7);
    check_value("dual_p2", Read_Data_2_o, 32'd78);
    #1 reset = 1'b0;
    #1;
    check_value("async_p1", Read_Data_1_o, 32'd0);
    check_value("async_p2", Read_Data_2_o, 32'd0);

    // Reset dominates a pending write
    Reg_Write_i = 1'b1;
    Write_Register_i = 5'd5;
    Write_Data_i = 32'hDEAD_BEEF;
    read_pair(5'd5, 5'd5);
    check_value("rstwr_comb", Read_Data_1_o, 32'd0);
    tick();
    Reg_Write_i = 1'b0;
    reset = 1'b1;
    #1;
    check_value("rstwr_r5", Read_Data_1_o, 32'd0);
    read_pair(5'd2, 5'd31);
    check_value("post_rst_r2", Read_Data_1_o, 32'd0);
    check_value("post_rst_r31", Read_Data_2_o, 32'd0);

    // Read-during-write on r25
    Reg_Write_i = 1'b1;
    Write_Register_i = 5'd25;
    Write_Data_i = 32'd6;
    tick();
    Write_Data_i = 32'h55;
    read_pair(5'd25, 5'd4);
`ifdef REG_FILE_BYPASS_EN
    exp_rdw = 32'h55;
`else
    exp_rdw = 32'd6;
`endif
    check_value("rdw_before", Read_Data_1_o, exp_rdw);
    check_value("rdw_other", Read_Data_2_o, 32'd0);
    tick();
    check_value("rdw_after", Read_Data_1_o, 32'h55);

    // Address 0 never forwarded
    Write_Register_i = 5'd0;
    Write_Data_i = 32'd9;
    read_pair(5'd0, 5'd25);
    check_value("fwd_r0", Read_Data_1_o, 32'd0);
    check_value("fwd_r25", Read_Data_2_o, 32'h55);
    tick();
    Reg_Write_i = 1'b0;
    #1;
    check_value("r0_final", Read_Data_1_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_run, checks_failed);
    $finish;
  end

endmodule
